// File: rtl/nn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nn_layer_sequencer
// Brief    : Walks hidden then output neurons of the 62-20-10 classifier,
//            driving the shared MAC datapath. NN_SEQ_HOLD_EN adds a hold stall.
// Revision : 1.0
// ============================================================================
module nn_layer_sequencer #(
    parameter int N_IN  = 62,
    parameter int N_HID = 20,
    parameter int N_OUT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef NN_SEQ_HOLD_EN
    input  logic        hold,
`endif
    output logic        busy,
    output logic        done,
    output logic        layer,
    output logic [4:0]  neuron_idx,
    output logic [5:0]  input_idx,
    output logic [10:0] w_addr,
    output logic [4:0]  b_addr,
    output logic        mac_clr,
    output logic        mac_en,
    output logic        bias_add,
    output logic        act_wr
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_ACC  = 3'd2,
        ST_BIAS = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [5:0] LAST_IN_HID  = 6'(N_IN - 1);
    localparam logic [5:0] LAST_IN_OUT  = 6'(N_HID - 1);
    localparam logic [4:0] LAST_NR_HID  = 5'(N_HID - 1);
    localparam logic [4:0] LAST_NR_OUT  = 5'(N_OUT - 1);

    state_t      state_q, state_d;
    logic        layer_q, layer_d;
    logic [4:0]  neuron_q, neuron_d;
    logic [5:0]  input_q, input_d;
    logic [10:0] waddr_q, waddr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        clr_q, clr_d;
    logic        en_q, en_d;
    logic        bias_q, bias_d;
    logic        wr_q, wr_d;
    logic [5:0]  last_in;
    logic [4:0]  last_nr;
    logic        stall;

`ifdef NN_SEQ_HOLD_EN
    assign stall = hold & busy_q;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        input_d  = input_q;
        waddr_d  = waddr_q;
        last_in  = layer_q ? LAST_IN_OUT : LAST_IN_HID;
        last_nr  = layer_q ? LAST_NR_OUT : LAST_NR_HID;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CLR;
                    layer_d  = 1'b0;
                    neuron_d = 5'd0;
                    input_d  = 6'd0;
                end
            end
            ST_CLR: begin
                state_d = ST_ACC;
                input_d = 6'd0;
                // Neuron n starts right after neuron n-1's last weight, so the
                // flat address is tracked incrementally instead of n*L + i.
                waddr_d = (neuron_q == 5'd0) ? 11'd0 : waddr_q + 11'd1;
            end
            ST_ACC: begin
                if (input_q == last_in) begin
                    state_d = ST_BIAS;
                end else begin
                    input_d = input_q + 6'd1;
                    waddr_d = waddr_q + 11'd1;
                end
            end
            ST_BIAS: state_d = ST_WB;
            ST_WB: begin
                if (neuron_q != last_nr) begin
                    state_d  = ST_CLR;
                    neuron_d = neuron_q + 5'd1;
                    input_d  = 6'd0;
                end else if (!layer_q) begin
                    state_d  = ST_CLR;
                    layer_d  = 1'b1;
                    neuron_d = 5'd0;
                    input_d  = 6'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A stalled cycle is replayed verbatim once hold drops.
        if (stall) begin
            state_d  = state_q;
            layer_d  = layer_q;
            neuron_d = neuron_q;
            input_d  = input_q;
            waddr_d  = waddr_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        clr_d  = (state_d == ST_CLR);
        en_d   = (state_d == ST_ACC);
        bias_d = (state_d == ST_BIAS);
        wr_d   = (state_d == ST_WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            layer_q  <= 1'b0;
            neuron_q <= 5'd0;
            input_q  <= 6'd0;
            waddr_q  <= 11'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            en_q     <= 1'b0;
            bias_q   <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            input_q  <= input_d;
            waddr_q  <= waddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            clr_q    <= clr_d;
            en_q     <= en_d;
            bias_q   <= bias_d;
            wr_q     <= wr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q & ~stall;
    assign layer      = layer_q;
    assign neuron_idx = neuron_q;
    assign input_idx  = input_q;
    assign w_addr     = waddr_q;
    assign b_addr     = neuron_q;
    assign mac_clr    = clr_q & ~stall;
    assign mac_en     = en_q & ~stall;
    assign bias_add   = bias_q & ~stall;
    assign act_wr     = wr_q & ~stall;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_layer_sequencer
// Brief    : Self-checking bench: event scoreboard plus table of key cycles.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_nn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
`ifdef NN_SEQ_HOLD_EN
    logic        hold = 1'b0;
`endif
    logic        busy, done, layer, mac_clr, mac_en, bias_add, act_wr;
    logic [4:0]  neuron_idx, b_addr;
    logic [5:0]  input_idx;
    logic [10:0] w_addr;

    always #5 clk = ~clk;

    nn_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef NN_SEQ_HOLD_EN
        .hold(hold),
`endif
        .busy(busy), .done(done), .layer(layer), .neuron_idx(neuron_idx),
        .input_idx(input_idx), .w_addr(w_addr), .b_addr(b_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .bias_add(bias_add), .act_wr(act_wr)
    );

    typedef struct {
        int          t;
        int          kind;   // 0 clr, 1 mac, 2 bias, 3 wb, 4 done
        logic        ly;
        logic [4:0]  nr;
        logic [5:0]  ix;
        logic [10:0] wa;
    } ev_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    typedef struct {
        int          t;
        logic [3:0]  strb;   // {mac_clr, mac_en, bias_add, act_wr}
        logic        dn;
        logic        bz;
        logic        ly;
        logic [4:0]  nr;
        logic [5:0]  ix;
        logic [10:0] wa;
        logic        chk_ix;
        logic        chk_ctx;
    } vec_t;

    ev_t  sb[$];
    win_t bw[$];
    vec_t tbl[16];

    int edge_cnt = 0;
    int checks = 0;
    int errors = 0;
    int n_clr = 0, n_en = 0, n_bias = 0, n_wr = 0, n_done = 0;
    localparam int NO_STALL = 1 << 30;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        ev_t        e;
        logic [4:0] s;
        logic       exp_b;
        int         gk;
        logic       ok;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].t < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d due at edge %0d not seen (now edge %0d)",
                         sb[0].kind, sb[0].t, edge_cnt);
                e = sb.pop_front();
            end
            s = {mac_clr, mac_en, bias_add, act_wr, done};
            if (s != 5'd0) begin
                checks++;
                gk = mac_clr ? 0 : mac_en ? 1 : bias_add ? 2 : act_wr ? 3 : 4;
                if ($countones(s) != 1) begin
                    errors++;
                    $display("FAIL strobe_exclusive: strobes %b at edge %0d, required one-hot", s, edge_cnt);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: strobes %b at edge %0d, required none", s, edge_cnt);
                end else begin
                    e = sb.pop_front();
                    ok = (e.t == edge_cnt) && (gk == e.kind);
                    if (e.kind != 4)
                        ok = ok && (layer == e.ly) && (neuron_idx == e.nr) && (b_addr == e.nr);
                    if (e.kind == 1)
                        ok = ok && (input_idx == e.ix) && (w_addr == e.wa);
                    if (!ok) begin
                        errors++;
                        $display("FAIL event: got kind %0d edge %0d L%0d n%0d b%0d i%0d a%0d, required kind %0d edge %0d L%0d n%0d i%0d a%0d",
                                 gk, edge_cnt, layer, neuron_idx, b_addr, input_idx, w_addr,
                                 e.kind, e.t, e.ly, e.nr, e.ix, e.wa);
                    end
                end
            end
            exp_b = 1'b0;
            foreach (bw[i]) if (edge_cnt >= bw[i].lo && edge_cnt <= bw[i].hi) exp_b = 1'b1;
            checks++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL busy: got %b at edge %0d, required %b", busy, edge_cnt, exp_b);
            end
            n_clr  += int'(mac_clr);
            n_en   += int'(mac_en);
            n_bias += int'(bias_add);
            n_wr   += int'(act_wr);
            n_done += int'(done);
        end
    end

    function automatic int shift(input int t, input int at, input int len);
        return (t >= at) ? t + len : t;
    endfunction

    task automatic add_ev(input int k, input int t, input int kind, input int ly,
                          input int n, input int i, input int a, input int at, input int len);
        ev_t e;
        e.t    = k + shift(t, at, len);
        e.kind = kind;
        e.ly   = ly[0];
        e.nr   = n[4:0];
        e.ix   = i[5:0];
        e.wa   = a[10:0];
        sb.push_back(e);
    endtask

    task automatic push_run(input int k, input int at, input int len);
        int t;
        win_t w;
        t = 0;
        for (int ly = 0; ly < 2; ly++) begin
            int nn;
            int ll;
            nn = (ly == 1) ? 10 : 20;
            ll = (ly == 1) ? 20 : 62;
            for (int n = 0; n < nn; n++) begin
                add_ev(k, t, 0, ly, n, 0, 0, at, len); t++;
                for (int i = 0; i < ll; i++) begin
                    add_ev(k, t, 1, ly, n, i, n * ll + i, at, len); t++;
                end
                add_ev(k, t, 2, ly, n, 0, 0, at, len); t++;
                add_ev(k, t, 3, ly, n, 0, 0, at, len); t++;
            end
        end
        add_ev(k, t, 4, 0, 0, 0, 0, at, len);
        w.lo = k;
        w.hi = k + 1530 + len;
        bw.push_back(w);
    endtask

    task automatic pulse_start(output int k);
        @(posedge clk); #1;
        start = 1'b1;
        k = edge_cnt + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_counts();
        n_clr = 0; n_en = 0; n_bias = 0; n_wr = 0; n_done = 0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int c;
        c = 0;
        while ((sb.size() > 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        #1;
        checks++;
        if (sb.size() > 0 || busy) begin
            errors++;
            $display("FAIL %s_timeout: %0d events pending, busy %b, required 0 and 0", nm, sb.size(), busy);
            sb.delete();
        end
        bw.delete();
    endtask

    task automatic chk(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic check_counts(input int m, input string nm);
        chk({nm, "_mac_clr_count"}, n_clr, 30 * m);
        chk({nm, "_mac_en_count"}, n_en, 1440 * m);
        chk({nm, "_bias_add_count"}, n_bias, 30 * m);
        chk({nm, "_act_wr_count"}, n_wr, 30 * m);
        chk({nm, "_done_count"}, n_done, m);
    endtask

    task automatic check_reset_vals(input string nm);
        logic [33:0] v;
        v = {busy, done, layer, neuron_idx, input_idx, w_addr, b_addr,
             mac_clr, mac_en, bias_add, act_wr};
        checks++;
        if (v !== 34'd0) begin
            errors++;
            $display("FAIL %s: outputs %h, required all zero", nm, v);
        end
    endtask

    task automatic check_table(input int k);
        logic ok;
        for (int i = 0; i < 16; i++) begin
            do @(negedge clk); while (edge_cnt < k + tbl[i].t);
            ok = ({mac_clr, mac_en, bias_add, act_wr} == tbl[i].strb) &&
                 (done == tbl[i].dn) && (busy == tbl[i].bz);
            if (tbl[i].chk_ctx)
                ok = ok && (layer == tbl[i].ly) && (neuron_idx == tbl[i].nr) && (b_addr == tbl[i].nr);
            if (tbl[i].chk_ix)
                ok = ok && (input_idx == tbl[i].ix) && (w_addr == tbl[i].wa);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL vec_t%0d: got strb %b done %b busy %b L%0d n%0d b%0d i%0d a%0d, required strb %b done %b busy %b L%0d n%0d i%0d a%0d",
                         tbl[i].t, {mac_clr, mac_en, bias_add, act_wr}, done, busy, layer,
                         neuron_idx, b_addr, input_idx, w_addr, tbl[i].strb, tbl[i].dn,
                         tbl[i].bz, tbl[i].ly, tbl[i].nr, tbl[i].ix, tbl[i].wa);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        //            t     strb    dn    bz    ly    nr     ix     wa        ix?   ctx?
        tbl[0]  = '{0,    4'b1000, 1'b0, 1'b1, 1'b0, 5'd0,  6'd0,  11'd0,    1'b0, 1'b1};
        tbl[1]  = '{1,    4'b0100, 1'b0, 1'b1, 1'b0, 5'd0,  6'd0,  11'd0,    1'b1, 1'b1};
        tbl[2]  = '{62,   4'b0100, 1'b0, 1'b1, 1'b0, 5'd0,  6'd61, 11'd61,   1'b1, 1'b1};
        tbl[3]  = '{63,   4'b0010, 1'b0, 1'b1, 1'b0, 5'd0,  6'd0,  11'd0,    1'b0, 1'b1};
        tbl[4]  = '{64,   4'b0001, 1'b0, 1'b1, 1'b0, 5'd0,  6'd0,  11'd0,    1'b0, 1'b1};
        tbl[5]  = '{65,   4'b1000, 1'b0, 1'b1, 1'b0, 5'd1,  6'd0,  11'd0,    1'b0, 1'b1};
        tbl[6]  = '{846,  4'b0100, 1'b0, 1'b1, 1'b0, 5'd13, 6'd0,  11'd806,  1'b1, 1'b1};
        tbl[7]  = '{907,  4'b0100, 1'b0, 1'b1, 1'b0, 5'd13, 6'd61, 11'd867,  1'b1, 1'b1};
        tbl[8]  = '{909,  4'b0001, 1'b0, 1'b1, 1'b0, 5'd13, 6'd0,  11'd0,    1'b0, 1'b1};
        tbl[9]  = '{1300, 4'b1000, 1'b0, 1'b1, 1'b1, 5'd0,  6'd0,  11'd0,    1'b0, 1'b1};
        tbl[10] = '{1301, 4'b0100, 1'b0, 1'b1, 1'b1, 5'd0,  6'd0,  11'd0,    1'b1, 1'b1};
        tbl[11] = '{1508, 4'b0100, 1'b0, 1'b1, 1'b1, 5'd9,  6'd0,  11'd180,  1'b1, 1'b1};
        tbl[12] = '{1527, 4'b0100, 1'b0, 1'b1, 1'b1, 5'd9,  6'd19, 11'd199,  1'b1, 1'b1};
        tbl[13] = '{1528, 4'b0010, 1'b0, 1'b1, 1'b1, 5'd9,  6'd0,  11'd0,    1'b0, 1'b1};
        tbl[14] = '{1530, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd0,  6'd0,  11'd0,    1'b0, 1'b0};
        tbl[15] = '{1531, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0,  11'd0,    1'b0, 1'b0};

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_vals("reset_async");
        #20 rst = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_strobes", int'({mac_clr, mac_en, bias_add, act_wr, done}), 0);

        // Single full inference with table of key cycles.
        clear_counts();
        pulse_start(k);
        push_run(k, NO_STALL, 0);
        check_table(k);
        wait_drain(2000, "full_run");
        check_counts(1, "full_run");

        // start held high: back-to-back inferences every 1532 cycles.
        clear_counts();
        @(posedge clk); #1;
        start = 1'b1;
        k = edge_cnt + 1;
        push_run(k, NO_STALL, 0);
        push_run(k + 1532, NO_STALL, 0);
        push_run(k + 3064, NO_STALL, 0);
        while (edge_cnt < k + 3064) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_drain(5000, "start_held");
        check_counts(3, "start_held");

        // Reset during ACC of hidden neuron 5 aborts without done.
        clear_counts();
        pulse_start(k);
        push_run(k, NO_STALL, 0);
        while (edge_cnt < k + 335) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1 check_reset_vals("reset_mid_async");
        sb.delete();
        bw.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        chk("abort_no_done", n_done, 0);
        chk("abort_idle_busy", int'(busy), 0);
        clear_counts();
        pulse_start(k);
        push_run(k, NO_STALL, 0);
        @(negedge clk);
        @(negedge clk);
        chk("restart_first_waddr", int'(w_addr), 0);
        wait_drain(2000, "restart");
        check_counts(1, "restart");

`ifdef NN_SEQ_HOLD_EN
        // Seven-cycle hold while w_addr=300 (hidden neuron 4, input 52).
        clear_counts();
        pulse_start(k);
        push_run(k, 313, 7);
        while (edge_cnt < k + 313) begin
            @(posedge clk); #1;
        end
        hold = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            chk("hold_strobes", int'({mac_clr, mac_en, bias_add, act_wr, done}), 0);
            chk("hold_waddr", int'(w_addr), 300);
            chk("hold_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
        hold = 1'b0;
        @(negedge clk);
        chk("hold_reissue_en", int'(mac_en), 1);
        chk("hold_reissue_waddr", int'(w_addr), 300);
        wait_drain(2000, "hold_run");
        check_counts(1, "hold_run");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
